// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths and arbiter state encodings.
package wb_port_arbiter_pkg;
    localparam int WORD_SIZE  = 32;
    localparam int REG_ADDR_W = 5;
    typedef enum logic [1:0] {
        WBA_IDLE  = 2'd0,
        WBA_SHARE = 2'd1,
        WBA_FORCE = 2'd2
    } wba_state_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: writeback request, LLU offer and register file port bundle.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
();
    logic                  RegWriteW;
    logic [REG_ADDR_W-1:0] RdW;
    logic [WORD_SIZE-1:0]  ResultW;
    logic                  llu_valid;
    logic [REG_ADDR_W-1:0] llu_rd;
    logic [WORD_SIZE-1:0]  llu_data;
    logic                  llu_ready;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [WORD_SIZE-1:0]  rf_wd;
    logic                  stall_w;
    logic [31:0]           pend_mask;
    modport slave (
        input  RegWriteW, RdW, ResultW, llu_valid, llu_rd, llu_data,
        output llu_ready, rf_we, rf_rd, rf_wd, stall_w, pend_mask
    );
    modport master (
        output RegWriteW, RdW, ResultW, llu_valid, llu_rd, llu_data,
        input  llu_ready, rf_we, rf_rd, rf_wd, stall_w, pend_mask
    );
endinterface

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: DEPTH-entry {rd, data} queue of LLU results with pending-register decode.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [WORD_SIZE-1:0]  i_data,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [WORD_SIZE-1:0]  o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CW-1:0]         o_cnt,
    output logic [31:0]           o_pend_mask
);
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_cnt;
    logic [DEPTH-1:0]      r_vld;
    logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
    logic [WORD_SIZE-1:0]  r_data [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_vld  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
            if (i_pop) r_vld[r_rptr] <= 1'b0;
            if (i_push) r_vld[r_wptr] <= 1'b1;
        end
    end

    // Payload needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_rd[r_wptr]   <= i_rd;
            r_data[r_wptr] <= i_data;
        end
    end

    always_comb begin
        o_pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_vld[i]) o_pend_mask[r_rd[i]] = 1'b1;
    end

    assign o_rd    = r_rd[r_rptr];
    assign o_data  = r_data[r_rptr];
    assign o_cnt   = r_cnt;
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register file write port between W stage and queued LLU results.
// Define WB_ARB_BYPASS_EN to let an LLU result write straight through an idle port.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(MAX_WAIT + 1);

    wba_state_e            r_state, w_state_nx;
    logic [GW-1:0]         r_age, w_age_nx;
    logic [CW-1:0]         w_cnt, w_cnt_nx;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [WORD_SIZE-1:0]  w_head_data;
    logic                  w_full, w_empty, w_preq, w_push, w_pop;
    logic                  w_grant_p, w_grant_h, w_grant_b, w_stall;

    assign w_preq = bus.RegWriteW && bus.RdW != '0;
    assign w_pop  = w_grant_h;
    assign w_push = bus.llu_valid && bus.llu_ready && bus.llu_rd != '0 && !w_grant_b;

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_rd        (bus.llu_rd),
        .i_data      (bus.llu_data),
        .o_rd        (w_head_rd),
        .o_data      (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_cnt       (w_cnt),
        .o_pend_mask (bus.pend_mask)
    );

    assign w_cnt_nx = w_cnt + CW'(w_push) - CW'(w_pop);
    assign w_age_nx = w_pop ? '0 : (!w_empty && r_age < GW'(MAX_WAIT)) ? r_age + 1'b1 : r_age;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WBA_IDLE;
            r_age   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_age   <= w_age_nx;
        end
    end

    // State tracks the FIFO status it will see next cycle, so it always matches count and age.
    always_comb begin
        w_state_nx = w_cnt_nx == '0 ? WBA_IDLE :
                     (w_cnt_nx == CW'(DEPTH) || w_age_nx >= GW'(MAX_WAIT)) ? WBA_FORCE : WBA_SHARE;
    end

    // Grants are gated by reset so the port stays quiet while rst is held low.
    always_comb begin
        w_grant_p = rst && w_preq && r_state != WBA_FORCE;
        w_grant_h = rst && (r_state == WBA_FORCE || (r_state == WBA_SHARE && !w_preq));
        w_stall   = rst && w_preq && r_state == WBA_FORCE;
`ifdef WB_ARB_BYPASS_EN
        w_grant_b = rst && r_state == WBA_IDLE && !w_preq && bus.llu_valid && bus.llu_rd != '0;
`else
        w_grant_b = 1'b0;
`endif
    end

    assign bus.llu_ready = !w_full || w_pop;
    assign bus.stall_w   = w_stall;
    assign bus.rf_we     = w_grant_p || w_grant_h || w_grant_b;
    assign bus.rf_rd     = w_grant_p ? bus.RdW : w_grant_h ? w_head_rd : w_grant_b ? bus.llu_rd : '0;
    assign bus.rf_wd     = w_grant_p ? bus.ResultW : w_grant_h ? w_head_data : w_grant_b ? bus.llu_data : '0;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of pipeline/LLU arbitration, aging, full drain and reset.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] rd,
                        input logic [31:0] wd, input logic stall);
        chk({tag, "_we"}, 32'(bus.rf_we), 32'(we));
        chk({tag, "_rd"}, 32'(bus.rf_rd), 32'(rd));
        chk({tag, "_wd"}, bus.rf_wd, wd);
        chk({tag, "_stall"}, 32'(bus.stall_w), 32'(stall));
    endtask

    initial begin
        bus.RegWriteW = 1'b1;
        bus.RdW       = 5'd5;
        bus.ResultW   = 32'hAAAA0001;
        bus.llu_valid = 1'b0;
        bus.llu_rd    = '0;
        bus.llu_data  = '0;
        #1 rst = 1'b0;
        #1;
        port("rst", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rst_ready", 32'(bus.llu_ready), 32'd1);
        chk("rst_pend", bus.pend_mask, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        port("pipe", 1'b1, 5'd5, 32'hAAAA0001, 1'b0);
        bus.RdW = 5'd0;
        #1;
        port("pipe_r0", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        bus.RegWriteW = 1'b0;
        bus.llu_valid = 1'b1;
        bus.llu_rd    = 5'd7;
        bus.llu_data  = 32'h12345678;
        #1;
`ifdef WB_ARB_BYPASS_EN
        port("llu_c0", 1'b1, 5'd7, 32'h12345678, 1'b0);
        tick();
        bus.llu_valid = 1'b0;
        #1;
        chk("llu_pend", bus.pend_mask, 32'h0);
        port("llu_c1", 1'b0, 5'd0, 32'h0, 1'b0);
`else
        port("llu_c0", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        bus.llu_valid = 1'b0;
        #1;
        chk("llu_pend", bus.pend_mask, 32'h80);
        port("llu_c1", 1'b1, 5'd7, 32'h12345678, 1'b0);
        tick();
        chk("llu_pend2", bus.pend_mask, 32'h0);
        port("llu_c2", 1'b0, 5'd0, 32'h0, 1'b0);
`endif
        tick();
        bus.RegWriteW = 1'b1;
        bus.RdW       = 5'd9;
        bus.ResultW   = 32'h99;
        bus.llu_valid = 1'b1;
        bus.llu_rd    = 5'd3;
        bus.llu_data  = 32'h33;
        #1;
        port("age_c0", 1'b1, 5'd9, 32'h99, 1'b0);
        tick();
        bus.llu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            port($sformatf("age_c%0d", i), 1'b1, 5'd9, 32'h99, 1'b0);
            chk($sformatf("age_pend%0d", i), bus.pend_mask, 32'h8);
            tick();
        end
        #1;
        port("age_c5", 1'b1, 5'd3, 32'h33, 1'b1);
        tick();
        port("age_c6", 1'b1, 5'd9, 32'h99, 1'b0);
        chk("age_pend6", bus.pend_mask, 32'h0);
        bus.llu_valid = 1'b1;
        bus.llu_rd    = 5'd1;
        bus.llu_data  = 32'h11;
        #1;
        port("full_a", 1'b1, 5'd9, 32'h99, 1'b0);
        tick();
        bus.llu_rd   = 5'd2;
        bus.llu_data = 32'h22;
        #1;
        port("full_b", 1'b1, 5'd9, 32'h99, 1'b0);
        chk("full_b_ready", 32'(bus.llu_ready), 32'd1);
        tick();
        bus.llu_rd   = 5'd4;
        bus.llu_data = 32'h44;
        #1;
        port("full_c", 1'b1, 5'd1, 32'h11, 1'b1);
        chk("full_c_ready", 32'(bus.llu_ready), 32'd1);
        chk("full_c_pend", bus.pend_mask, 32'h6);
        tick();
        bus.llu_valid = 1'b0;
        #1;
        port("full_d", 1'b1, 5'd2, 32'h22, 1'b1);
        chk("full_d_pend", bus.pend_mask, 32'h14);
        tick();
        port("full_e", 1'b1, 5'd9, 32'h99, 1'b0);
        tick();
        bus.RegWriteW = 1'b0;
        #1;
        port("full_f", 1'b1, 5'd4, 32'h44, 1'b0);
        tick();
        port("full_g", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("full_g_pend", bus.pend_mask, 32'h0);
        bus.llu_valid = 1'b1;
        bus.llu_rd    = 5'd0;
        bus.llu_data  = 32'h55;
        #1;
        chk("drop_ready", 32'(bus.llu_ready), 32'd1);
        port("drop_c0", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        bus.llu_valid = 1'b0;
        #1;
        port("drop_c1", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("drop_pend", bus.pend_mask, 32'h0);
        tick();
        bus.RegWriteW = 1'b1;
        bus.llu_valid = 1'b1;
        bus.llu_rd    = 5'd5;
        bus.llu_data  = 32'h5;
        tick();
        bus.llu_rd   = 5'd6;
        bus.llu_data = 32'h6;
        tick();
        bus.llu_valid = 1'b0;
        #1;
        port("mid_pre", 1'b1, 5'd5, 32'h5, 1'b1);
        #2 rst = 1'b0;
        #1;
        port("mid_rst", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("mid_ready", 32'(bus.llu_ready), 32'd1);
        chk("mid_pend", bus.pend_mask, 32'h0);
        tick();
        bus.RegWriteW = 1'b0;
        rst = 1'b1;
        #1;
        port("post_c0", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        port("post_c1", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("post_pend", bus.pend_mask, 32'h0);
        tick();
        port("post_c2", 1'b0, 5'd0, 32'h0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the pipeline writeback result (W stage) and a long-latency unit (LLU, e.g. multi-cycle mul/div) that completes out of band. LLU results are queued in a small FIFO. Normally the pipeline wins the port, but an aged or full queue forces a drain and stalls the W stage. The block sits between the writeback stage and the register file, and also feeds the hazard unit.

## Interface
Parameters:
- DEPTH, 2: LLU result FIFO entries (power of two, ≥2).
- MAX_WAIT, 4: cycles a FIFO head may lose arbitration before a forced drain.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteW  in  1  pipeline write request.
- RdW  in  5  pipeline destination register.
- ResultW  in  WORD_SIZE  pipeline write data.
- llu_valid  in  1  LLU result offered.
- llu_rd  in  5  LLU destination register.
- llu_data  in  WORD_SIZE  LLU result.
- llu_ready  out  1  FIFO can accept this cycle.
- rf_we  out  1  register file write enable.
- rf_rd  out  5  register file write address.
- rf_wd  out  WORD_SIZE  register file write data.
- stall_w  out  1  W stage write not granted; hazard unit holds W.
- pend_mask  out  32  bit i set when any FIFO entry targets register i.

## Operation
- Pipeline request: preq = RegWriteW && RdW != 0. RdW = 0 never requests and is never stalled.
- LLU push: occurs when llu_valid && llu_ready.
  - llu_rd = 0 is accepted and dropped; it is never enqueued.
  - llu_ready = !full, or full with a pop in the same cycle.
- FIFO head request: hreq = !empty.
- States:
  - IDLE: empty.
  - SHARE: non-empty, age < MAX_WAIT, not full.
  - FORCE: non-empty, and either age ≥ MAX_WAIT or full.
- Grant rules:
  - IDLE: grant the pipeline if preq.
  - SHARE: grant the pipeline if preq, otherwise grant the head.
  - FORCE: grant the head. If preq, assert stall_w.
- rf_we = any grant. rf_rd and rf_wd are muxed from the granted source. When no grant, rf_rd and rf_wd are 0.
- Head age counter:
  - Increments when hreq and the head is not granted; saturates at MAX_WAIT.
  - Clears on pop and on reset.
- Simultaneous push and pop when full: allowed; count is unchanged.
- Push into empty FIFO: the entry is first eligible in the next cycle (no bypass unless the configuration macro is defined).
- pend_mask is built from registered FIFO contents only. The hazard unit must not issue a pipeline write to a register whose pend_mask bit is set. The arbiter does not check WAW ordering.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

## Timing
- Pipeline write: combinational, written in the same cycle as RegWriteW.
- LLU result: earliest write is the cycle after acceptance.
- stall_w is combinational. The hazard unit must hold RegWriteW, RdW and ResultW stable while stall_w is high.
- Worst-case pipeline stall: DEPTH consecutive cycles, i.e. a full drain. After a forced pop, age is 0, so the pipeline regains priority unless the FIFO is still full.
- Reset, asynchronous and mid-operation:
  - FIFO emptied, all entries discarded, age = 0, state IDLE.
  - Outputs: rf_we = 0, rf_rd = 0, rf_wd = 0, stall_w = 0, pend_mask = 0, llu_ready = 1.

## Configuration
- WB_ARB_BYPASS_EN defined:
  - When the FIFO is empty, !preq and the push has llu_rd ≠ 0, the LLU result is written to the register file in the same cycle and not enqueued.
  - pend_mask is unaffected.
- Undefined: every LLU result passes through the FIFO, with a minimum latency of 1 cycle.

## Structure
- Shared package/constants (constants.v):
  - WORD_SIZE.
  - REG_ADDR_W = 5.
  - State encodings WBA_IDLE, WBA_SHARE, WBA_FORCE.
- One sub-module: wb_result_fifo, holding the DEPTH-entry {rd, data} storage, pointers, count, full/empty and the pend_mask decode.
- Arbitration, the age counter and the output mux stay in wb_port_arbiter.

## Test plan
- Pipeline only: RegWriteW = 1, RdW = 5, ResultW = 0xAAAA0001 -> same-cycle rf_we = 1, rf_rd = 5, stall_w = 0. With RdW = 0 -> rf_we = 0, stall_w = 0.
- LLU idle port: push rd = 7, data = 0x12345678 with no pipeline traffic -> write in cycle +1; pend_mask bit 7 high for exactly 1 cycle. With the bypass macro defined: write in the same cycle, pend_mask stays 0.
- Aging: push rd = 3, then preq every cycle -> pipeline granted for 4 cycles. Cycle 5: head is written and stall_w = 1 for 1 cycle. Age returns to 0.
- Full: push rd = 1 and rd = 2 back-to-back with continuous preq -> FIFO full, state FORCE, two stalled drain cycles in order rd 1 then rd 2; llu_ready stays high across the pop.
- Rd = 0 drop: push llu_rd = 0 -> accepted, FIFO count unchanged, no rf write.
- Reset mid-drain: FIFO full and stall_w = 1, assert rst low -> all outputs zero immediately, llu_ready = 1, pend_mask = 0. After release, no stale writes occur.
